// File: rtl/riscv_i32_debug_sequencer_pkg.sv
// Shared types and encodings for the debug-register access sequencer.
// Covers debug op codes, response status codes, FSM states and flattened channel structs.
package riscv_i32_debug_sequencer_pkg;

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;

  localparam logic [1:0] ST_OK          = 2'd0;
  localparam logic [1:0] ST_NOT_HALTED  = 2'd1;
  localparam logic [1:0] ST_TIMEOUT     = 2'd2;
  localparam logic [1:0] ST_ILLEGAL     = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESPOND
  } seq_state_t;

  typedef struct packed {
    logic        write;
    logic        gpr;
    logic [11:0] address;
    logic [31:0] data;
  } dbg_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  status;
  } dbg_resp_t;

  typedef struct packed {
    logic [31:0] data;
    logic        illegal;
  } exec_done_t;

  // Debug decoder field layout: [12]=gpr, [11:0]=address, upper bits zero.
  function automatic logic [15:0] debug_field(input logic gpr, input logic [11:0] address);
    return {3'b000, gpr, address};
  endfunction

endpackage

// File: rtl/riscv_i32_debug_sequencer_if.sv
// Debug-module request/response channel plus the pipeline debug-instruction channel.
// slave = sequencer side, master = debug module / pipeline side.
interface riscv_i32_debug_sequencer_if;
  logic        core_halted;
  logic        dbg_req__valid;
  logic        dbg_req__write;
  logic        dbg_req__gpr;
  logic [11:0] dbg_req__address;
  logic [31:0] dbg_req__data;
  logic        dbg_req__ready;
  logic        dbg_resp__valid;
  logic        dbg_resp__ack;
  logic [31:0] dbg_resp__data;
  logic [1:0]  dbg_resp__status;
  logic [31:0] instruction__data;
  logic        instruction__debug__valid;
  logic [1:0]  instruction__debug__debug_op;
  logic [15:0] instruction__debug__data;
  logic        fetch_accept;
  logic        exec_done__valid;
  logic [31:0] exec_done__data;
  logic        exec_done__illegal;

  modport slave (
    input  core_halted, dbg_req__valid, dbg_req__write, dbg_req__gpr, dbg_req__address,
           dbg_req__data, dbg_resp__ack, fetch_accept, exec_done__valid, exec_done__data,
           exec_done__illegal,
    output dbg_req__ready, dbg_resp__valid, dbg_resp__data, dbg_resp__status,
           instruction__data, instruction__debug__valid, instruction__debug__debug_op,
           instruction__debug__data
  );

  modport master (
    output core_halted, dbg_req__valid, dbg_req__write, dbg_req__gpr, dbg_req__address,
           dbg_req__data, dbg_resp__ack, fetch_accept, exec_done__valid, exec_done__data,
           exec_done__illegal,
    input  dbg_req__ready, dbg_resp__valid, dbg_resp__data, dbg_resp__status,
           instruction__data, instruction__debug__valid, instruction__debug__debug_op,
           instruction__debug__data
  );
endinterface

// File: rtl/riscv_i32_debug_sequencer.sv
// Injects one debug GPR/CSR access at a time into the halted RV32 pipeline and
// returns data/status, aborting with a timeout if the pipeline never completes it.
module riscv_i32_debug_sequencer
  import riscv_i32_debug_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  riscv_i32_debug_sequencer_if.slave  bus
);

  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

  seq_state_t  state;
  logic [7:0]  count;
  dbg_req_t    req;
  dbg_resp_t   resp;
  exec_done_t  done;
  logic        ready;
  logic        resp_valid;
  logic        instr_valid;
  logic [1:0]  instr_op;
  logic [15:0] instr_field;
  logic [31:0] instr_data;

  assign done = '{data: bus.exec_done__data, illegal: bus.exec_done__illegal};

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      count       <= '0;
      ready       <= 1'b0;
      resp_valid  <= 1'b0;
      resp        <= '0;
      instr_valid <= 1'b0;
      instr_op    <= '0;
      instr_field <= '0;
      instr_data  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          ready <= 1'b1;
          if (bus.dbg_req__valid && ready) begin
            req   <= '{write: bus.dbg_req__write, gpr: bus.dbg_req__gpr,
                       address: bus.dbg_req__address, data: bus.dbg_req__data};
            ready <= 1'b0;
            if (!bus.core_halted) begin
              state      <= S_RESPOND;
              resp_valid <= 1'b1;
              resp       <= '{data: '0, status: ST_NOT_HALTED};
            end else if (bus.dbg_req__gpr && (bus.dbg_req__address[11:5] != 7'd0)) begin
              state      <= S_RESPOND;
              resp_valid <= 1'b1;
              resp       <= '{data: '0, status: ST_ILLEGAL};
            end else begin
              state       <= S_ISSUE;
              count       <= '0;
              instr_valid <= 1'b1;
              instr_op    <= bus.dbg_req__write ? OP_WRITE : OP_READ;
              instr_field <= debug_field(bus.dbg_req__gpr, bus.dbg_req__address);
              instr_data  <= bus.dbg_req__data;
            end
          end
        end

        S_ISSUE: begin
          count <= count + 8'd1;
          // Acceptance beats both a simultaneous halt drop and the timeout.
          if (bus.fetch_accept) begin
            state       <= S_WAIT;
            instr_valid <= 1'b0;
            instr_op    <= '0;
            instr_field <= '0;
            instr_data  <= '0;
          end else if (!bus.core_halted || (count == LAST_COUNT)) begin
            state       <= S_RESPOND;
            resp_valid  <= 1'b1;
            resp        <= '{data: '0, status: bus.core_halted ? ST_TIMEOUT : ST_NOT_HALTED};
            instr_valid <= 1'b0;
            instr_op    <= '0;
            instr_field <= '0;
            instr_data  <= '0;
          end
        end

        S_WAIT: begin
          count <= count + 8'd1;
          if (bus.exec_done__valid) begin
            state      <= S_RESPOND;
            resp_valid <= 1'b1;
            resp.status <= done.illegal ? ST_ILLEGAL : ST_OK;
            resp.data   <= (!done.illegal && !req.write) ? done.data : 32'd0;
          end else if (count == LAST_COUNT) begin
            state      <= S_RESPOND;
            resp_valid <= 1'b1;
            resp       <= '{data: '0, status: ST_TIMEOUT};
          end
        end

        S_RESPOND: begin
          if (bus.dbg_resp__ack) begin
            state      <= S_IDLE;
            resp_valid <= 1'b0;
            resp       <= '0;
            ready      <= 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.dbg_req__ready               = ready;
  assign bus.dbg_resp__valid              = resp_valid;
  assign bus.dbg_resp__data               = resp.data;
  assign bus.dbg_resp__status             = resp.status;
  assign bus.instruction__debug__valid    = instr_valid;
  assign bus.instruction__debug__debug_op = instr_op;
  assign bus.instruction__debug__data     = instr_field;
  assign bus.instruction__data            = instr_data;

endmodule

// File: tb/tb_riscv_i32_debug_sequencer.sv
// Directed bench for the debug sequencer: GPR/CSR accesses, error paths,
// timeout boundary, response hold-off and mid-operation reset.
module tb_riscv_i32_debug_sequencer;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   n;

  riscv_i32_debug_sequencer_if bus ();

  riscv_i32_debug_sequencer #(.TIMEOUT_CYCLES(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are read at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic write, input logic gpr, input logic [11:0] addr,
                        input logic [31:0] data);
    bus.dbg_req__valid   = 1'b1;
    bus.dbg_req__write   = write;
    bus.dbg_req__gpr     = gpr;
    bus.dbg_req__address = addr;
    bus.dbg_req__data    = data;
    tick();
    bus.dbg_req__valid   = 1'b0;
  endtask

  task automatic ack_resp();
    bus.dbg_resp__ack = 1'b1;
    tick();
    bus.dbg_resp__ack = 1'b0;
  endtask

  task automatic check_resp(input string tag, input logic [1:0] status, input logic [31:0] data);
    check({tag, "_valid"}, 32'(bus.dbg_resp__valid), 32'd1);
    check({tag, "_status"}, 32'(bus.dbg_resp__status), 32'(status));
    check({tag, "_data"}, bus.dbg_resp__data, data);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 32'(bus.dbg_req__ready), 32'd0);
    check({tag, "_rvalid"}, 32'(bus.dbg_resp__valid), 32'd0);
    check({tag, "_rdata"}, bus.dbg_resp__data, 32'd0);
    check({tag, "_rstatus"}, 32'(bus.dbg_resp__status), 32'd0);
    check({tag, "_ivalid"}, 32'(bus.instruction__debug__valid), 32'd0);
    check({tag, "_iop"}, 32'(bus.instruction__debug__debug_op), 32'd0);
    check({tag, "_ifield"}, 32'(bus.instruction__debug__data), 32'd0);
    check({tag, "_idata"}, bus.instruction__data, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.core_halted        = 1'b1;
    bus.dbg_req__valid     = 1'b0;
    bus.dbg_req__write     = 1'b0;
    bus.dbg_req__gpr       = 1'b0;
    bus.dbg_req__address   = '0;
    bus.dbg_req__data      = '0;
    bus.dbg_resp__ack      = 1'b0;
    bus.fetch_accept       = 1'b0;
    bus.exec_done__valid   = 1'b0;
    bus.exec_done__data    = '0;
    bus.exec_done__illegal = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    reset = 1'b0;
    tick();
    check("ready_after_reset", 32'(bus.dbg_req__ready), 32'd1);

    // Halted GPR read of x5
    accept(1'b0, 1'b1, 12'h005, 32'h0);
    check("gpr_rd_ivalid", 32'(bus.instruction__debug__valid), 32'd1);
    check("gpr_rd_field", 32'(bus.instruction__debug__data), 32'h1005);
    check("gpr_rd_op", 32'(bus.instruction__debug__debug_op), 32'd0);
    check("gpr_rd_ready", 32'(bus.dbg_req__ready), 32'd0);
    bus.fetch_accept = 1'b1;
    tick();
    bus.fetch_accept = 1'b0;
    check("gpr_rd_wait_ivalid", 32'(bus.instruction__debug__valid), 32'd0);
    check("gpr_rd_wait_rvalid", 32'(bus.dbg_resp__valid), 32'd0);
    bus.exec_done__valid = 1'b1;
    bus.exec_done__data  = 32'hDEADBEEF;
    tick();
    bus.exec_done__valid = 1'b0;
    check_resp("gpr_rd", 2'd0, 32'hDEADBEEF);
    ack_resp();
    check("gpr_rd_idle_ready", 32'(bus.dbg_req__ready), 32'd1);
    check("gpr_rd_idle_rvalid", 32'(bus.dbg_resp__valid), 32'd0);

    // Halted CSR write 0x7B0
    accept(1'b1, 1'b0, 12'h7B0, 32'h12345678);
    check("csr_wr_field", 32'(bus.instruction__debug__data), 32'h07B0);
    check("csr_wr_op", 32'(bus.instruction__debug__debug_op), 32'd1);
    check("csr_wr_idata", bus.instruction__data, 32'h12345678);
    bus.fetch_accept = 1'b1;
    tick();
    bus.fetch_accept = 1'b0;
    bus.exec_done__valid = 1'b1;
    bus.exec_done__data  = 32'hAAAA5555;
    tick();
    bus.exec_done__valid = 1'b0;
    check_resp("csr_wr", 2'd0, 32'h0);
    ack_resp();

    // Core not halted: answered immediately, nothing issued
    bus.core_halted = 1'b0;
    accept(1'b0, 1'b0, 12'h300, 32'h0);
    check_resp("not_halted", 2'd1, 32'h0);
    check("not_halted_ivalid", 32'(bus.instruction__debug__valid), 32'd0);
    ack_resp();
    bus.core_halted = 1'b1;

    // GPR number out of range
    accept(1'b0, 1'b1, 12'h020, 32'h0);
    check_resp("gpr_range", 2'd3, 32'h0);
    check("gpr_range_ivalid", 32'(bus.instruction__debug__valid), 32'd0);
    ack_resp();

    // Pipeline flags CSR read 0xFFF illegal
    accept(1'b0, 1'b0, 12'hFFF, 32'h0);
    check("csr_ill_field", 32'(bus.instruction__debug__data), 32'h0FFF);
    bus.fetch_accept = 1'b1;
    tick();
    bus.fetch_accept = 1'b0;
    bus.exec_done__valid   = 1'b1;
    bus.exec_done__illegal = 1'b1;
    bus.exec_done__data    = 32'h00001234;
    tick();
    bus.exec_done__valid   = 1'b0;
    bus.exec_done__illegal = 1'b0;
    check_resp("csr_ill", 2'd3, 32'h0);
    ack_resp();

    // Never accepted: timeout exactly 64 cycles after ISSUE entry
    accept(1'b0, 1'b0, 12'h341, 32'h0);
    n = 0;
    while (!bus.dbg_resp__valid && n < 200) begin
      tick();
      n++;
    end
    check("timeout_cycles", 32'(n), 32'd64);
    check_resp("timeout", 2'd2, 32'h0);
    bus.exec_done__valid = 1'b1;
    bus.exec_done__data  = 32'h55555555;
    tick();
    bus.exec_done__valid = 1'b0;
    check_resp("late_done", 2'd2, 32'h0);
    ack_resp();

    // Completion on the final count wins over timeout
    accept(1'b0, 1'b0, 12'h300, 32'h0);
    bus.fetch_accept = 1'b1;
    tick();
    bus.fetch_accept = 1'b0;
    for (int i = 0; i < 62; i++) tick();
    check("edge_not_yet", 32'(bus.dbg_resp__valid), 32'd0);
    bus.exec_done__valid = 1'b1;
    bus.exec_done__data  = 32'hCAFEF00D;
    tick();
    bus.exec_done__valid = 1'b0;
    check_resp("edge_done", 2'd0, 32'hCAFEF00D);
    ack_resp();

    // Response held without ack while a new request waits
    bus.core_halted = 1'b0;
    accept(1'b0, 1'b0, 12'h300, 32'h0);
    bus.dbg_req__valid   = 1'b1;
    bus.dbg_req__gpr     = 1'b1;
    bus.dbg_req__address = 12'h00A;
    for (int i = 0; i < 5; i++) begin
      check("hold_ready", 32'(bus.dbg_req__ready), 32'd0);
      check("hold_rvalid", 32'(bus.dbg_resp__valid), 32'd1);
      tick();
    end
    bus.core_halted   = 1'b1;
    bus.dbg_resp__ack = 1'b1;
    tick();
    bus.dbg_resp__ack = 1'b0;
    check("post_ack_ready", 32'(bus.dbg_req__ready), 32'd1);
    check("post_ack_ivalid", 32'(bus.instruction__debug__valid), 32'd0);
    tick();
    bus.dbg_req__valid = 1'b0;
    check("held_req_ivalid", 32'(bus.instruction__debug__valid), 32'd1);
    check("held_req_field", 32'(bus.instruction__debug__data), 32'h100A);

    // Reset while in WAIT
    bus.fetch_accept = 1'b1;
    tick();
    bus.fetch_accept = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_all_zero("mid_reset");
    tick();
    check("mid_reset_ready", 32'(bus.dbg_req__ready), 32'd1);
    check("mid_reset_rvalid", 32'(bus.dbg_resp__valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
